// File: rtl/ext_mem_responder.sv
// ext_mem_responder: single-port external memory model with fixed
// per-operation latency. One request is latched at a time and completed
// with a one-cycle mem_ready pulse; read data is valid only in that cycle.
module ext_mem_responder #(
  parameter int WORD_SIZE     = 32,
  parameter int DEPTH_LOG2    = 10,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          mem_addr,
  input  logic                 en_ext_mem_re,
  input  logic                 en_ext_mem_wr,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 mem_ready,
  output logic                 busy
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);

  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t                state, next_state;
  logic [CW-1:0]         cnt;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [WORD_SIZE-1:0]  wdata;
  logic [WORD_SIZE-1:0]  mem [DEPTH];

  logic req;
  logic accept;
  logic commit;
  logic unused_addr;

  assign req         = en_ext_mem_re | en_ext_mem_wr;
  assign accept      = req && ((state == ST_IDLE) || (state == ST_RESP));
  assign commit      = (state == ST_BUSY) && (cnt == '0);
  assign mem_ready   = (state == ST_RESP);
  assign busy        = (state == ST_BUSY);
  // Byte-offset and above-depth address bits are deliberately dropped.
  assign unused_addr = ^{mem_addr[31:DEPTH_LOG2+2], mem_addr[1:0]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: RESP may accept a new request directly for gapless service.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (req) next_state = ST_BUSY;
      ST_BUSY: if (cnt == '0) next_state = ST_RESP;
      ST_RESP: next_state = req ? ST_BUSY : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Request latch, latency counter and read-data register (zero outside RESP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_wr    <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
      data_out <= '0;
    end else begin
      data_out <= '0;
      if (commit && !op_wr) data_out <= mem[idx];
      if (accept) begin
        op_wr <= en_ext_mem_wr;
        idx   <= mem_addr[DEPTH_LOG2+1:2];
        wdata <= data_in;
        cnt   <= en_ext_mem_wr ? WR_LOAD : RD_LOAD;
      end else if ((state == ST_BUSY) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Storage write; commit is gated by state, so reset before commit leaves memory untouched.
  always_ff @(posedge clk) begin
    if (commit && op_wr) mem[idx] <= wdata;
  end

endmodule
